// File: rtl/dcache_writeback_unit.sv
// D-cache victim writeback: reads one line from the data array and streams it to memory.
// Define DCACHE_WB_PERF_EN to build the memory-side stall cycle counter.
module dcache_writeback_unit #(
  parameter int LINE_WORDS = 16,
  parameter int BUF_DEPTH  = 3,
  parameter int NWAYS      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [5:0]  io_req_bits_idx,
  input  logic [19:0] io_req_bits_tag,
  input  logic [3:0]  io_req_bits_way_en,
  output logic        io_data_req_valid,
  input  logic        io_data_req_ready,
  output logic [11:0] io_data_req_bits_addr,
  output logic        io_data_req_bits_write,
  output logic [31:0] io_data_req_bits_wdata,
  output logic [3:0]  io_data_req_bits_eccMask,
  output logic [3:0]  io_data_req_bits_way_en,
  input  logic [31:0] io_data_resp_0,
  input  logic [31:0] io_data_resp_1,
  input  logic [31:0] io_data_resp_2,
  input  logic [31:0] io_data_resp_3,
  output logic        io_mem_valid,
  input  logic        io_mem_ready,
  output logic [31:0] io_mem_bits_addr,
  output logic [31:0] io_mem_bits_data,
  output logic        io_mem_bits_last,
  output logic        io_done,
  output logic [15:0] io_perf_stall_cycles
);

  localparam int WW = $clog2(LINE_WORDS);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = OW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_nx;
  logic [5:0]        idx_q;
  logic [19:0]       tag_q;
  logic [NWAYS-1:0]  way_q;
  logic [WW-1:0]     rd_cnt, wr_cnt;
  logic              rd_fin, inflight, done_q;
  logic [31:0]       fifo [BUF_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [OW-1:0]     occ;
  logic [CW-1:0]     credit;
  logic [31:0]       resp [NWAYS];
  logic [31:0]       resp_sel;
  logic              accept, rd_fire, push, pop, last_fire;

  assign resp[0] = io_data_resp_0;
  assign resp[1] = io_data_resp_1;
  assign resp[2] = io_data_resp_2;
  assign resp[3] = io_data_resp_3;

  always_comb begin
    resp_sel = '0;
    for (int i = 0; i < NWAYS; i++)
      if (way_q[i]) resp_sel = resp_sel | resp[i];
  end

  // credit uses registered occupancy, so a same-cycle pop never frees a slot
  assign credit    = CW'(occ) + CW'(inflight);
  assign accept    = io_req_valid & io_req_ready;
  assign rd_fire   = io_data_req_valid & io_data_req_ready;
  assign push      = inflight;
  assign pop       = io_mem_valid & io_mem_ready;
  assign last_fire = pop & io_mem_bits_last;

  assign io_data_req_valid        = (state == ACTIVE) & ~rd_fin &
                                    (credit < CW'(BUF_DEPTH));
  assign io_data_req_bits_addr    = {idx_q, rd_cnt, 2'b00};
  assign io_data_req_bits_write   = 1'b0;
  assign io_data_req_bits_wdata   = '0;
  assign io_data_req_bits_eccMask = '0;
  assign io_data_req_bits_way_en  = way_q;

  assign io_mem_valid     = (occ != '0);
  assign io_mem_bits_addr = {tag_q, idx_q, wr_cnt, 2'b00};
  assign io_mem_bits_data = fifo[rptr];
  assign io_mem_bits_last = (wr_cnt == WW'(LINE_WORDS - 1));
  assign io_done          = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    io_req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        io_req_ready = 1'b1;
        if (io_req_valid) state_nx = ACTIVE;
      end
      ACTIVE: if (last_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      tag_q    <= '0;
      way_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_fin   <= 1'b0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (accept) begin
        idx_q  <= io_req_bits_idx;
        tag_q  <= io_req_bits_tag;
        way_q  <= io_req_bits_way_en;
        rd_cnt <= '0;
        wr_cnt <= '0;
        rd_fin <= 1'b0;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == WW'(LINE_WORDS - 1)) rd_fin <= 1'b1;
      end
      inflight <= rd_fire;
      done_q   <= last_fire;
      if (push) begin
        fifo[wptr] <= resp_sel;
        wptr <= (wptr == PW'(BUF_DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr   <= (rptr == PW'(BUF_DEPTH - 1)) ? '0 : rptr + 1'b1;
        wr_cnt <= wr_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef DCACHE_WB_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (io_mem_valid & ~io_mem_ready & (stall_q != 16'hFFFF))
      stall_q <= stall_q + 1'b1;
  end

  assign io_perf_stall_cycles = stall_q;
`else
  assign io_perf_stall_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_dcache_writeback_unit.sv
// Bench for dcache_writeback_unit: directed and randomized evictions
// checked against a line-level model of the data array and beat stream.
module tb_dcache_writeback_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [5:0]  io_req_bits_idx = '0;
  logic [19:0] io_req_bits_tag = '0;
  logic [3:0]  io_req_bits_way_en = '0;
  logic        io_data_req_valid;
  logic        io_data_req_ready = 1'b0;
  logic [11:0] io_data_req_bits_addr;
  logic        io_data_req_bits_write;
  logic [31:0] io_data_req_bits_wdata;
  logic [3:0]  io_data_req_bits_eccMask;
  logic [3:0]  io_data_req_bits_way_en;
  logic [31:0] io_data_resp_0, io_data_resp_1;
  logic [31:0] io_data_resp_2, io_data_resp_3;
  logic        io_mem_valid;
  logic        io_mem_ready = 1'b0;
  logic [31:0] io_mem_bits_addr;
  logic [31:0] io_mem_bits_data;
  logic        io_mem_bits_last;
  logic        io_done;
  logic [15:0] io_perf_stall_cycles;

  always #5 clock = ~clock;

  dcache_writeback_unit dut (
    .clock(clock),
    .reset_n(reset_n),
    .io_req_valid(io_req_valid),
    .io_req_ready(io_req_ready),
    .io_req_bits_idx(io_req_bits_idx),
    .io_req_bits_tag(io_req_bits_tag),
    .io_req_bits_way_en(io_req_bits_way_en),
    .io_data_req_valid(io_data_req_valid),
    .io_data_req_ready(io_data_req_ready),
    .io_data_req_bits_addr(io_data_req_bits_addr),
    .io_data_req_bits_write(io_data_req_bits_write),
    .io_data_req_bits_wdata(io_data_req_bits_wdata),
    .io_data_req_bits_eccMask(io_data_req_bits_eccMask),
    .io_data_req_bits_way_en(io_data_req_bits_way_en),
    .io_data_resp_0(io_data_resp_0),
    .io_data_resp_1(io_data_resp_1),
    .io_data_resp_2(io_data_resp_2),
    .io_data_resp_3(io_data_resp_3),
    .io_mem_valid(io_mem_valid),
    .io_mem_ready(io_mem_ready),
    .io_mem_bits_addr(io_mem_bits_addr),
    .io_mem_bits_data(io_mem_bits_data),
    .io_mem_bits_last(io_mem_bits_last),
    .io_done(io_done),
    .io_perf_stall_cycles(io_perf_stall_cycles)
  );

  int total = 0;
  int bad = 0;

  // data array model: responds one cycle after a grant, junk otherwise
  logic [31:0] arr [4][16];
  logic        gvalid = 1'b0;
  logic [3:0]  gword = '0;
  logic [31:0] junk = 32'h5A5A_A5A5;

  always @(posedge clock) begin
    gvalid <= io_data_req_valid & io_data_req_ready;
    gword  <= io_data_req_bits_addr[5:2];
    junk   <= $urandom;
  end

  assign io_data_resp_0 = gvalid ? arr[0][gword] : junk;
  assign io_data_resp_1 = gvalid ? arr[1][gword] : ~junk;
  assign io_data_resp_2 = gvalid ? arr[2][gword] : junk ^ 32'h0F0F_0F0F;
  assign io_data_resp_3 = gvalid ? arr[3][gword] : junk + 32'd7;

  logic [136:0] outs;
  assign outs = {io_data_req_valid, io_data_req_bits_addr,
                 io_data_req_bits_write, io_data_req_bits_wdata,
                 io_data_req_bits_eccMask, io_data_req_bits_way_en,
                 io_mem_valid, io_mem_bits_addr, io_mem_bits_data,
                 io_mem_bits_last, io_done, io_perf_stall_cycles};

  // observations of one line transfer
  logic [64:0] ob [$];
  int          ob_cyc [$];
  logic [11:0] rd_addr [$];
  int          rd_cyc [$];
  int          done_cyc, hold_viol, const_viol, extra_acc;
  logic        acc0, next_acc;

  function automatic logic [31:0] exp_word(input logic [3:0] way, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (way[i]) r = r | arr[i][w];
    return r;
  endfunction

  task automatic fill_arr();
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 16; w++) arr[i][w] = $urandom;
  endtask

  // drives one eviction; cycle 0 is the accept cycle
  task automatic run_line(
    input logic [5:0] idx, input logic [19:0] tag, input logic [3:0] way,
    input int mstall, input int dmode, input int mmode,
    input bit skip_acc, input bit hold,
    input logic [5:0] idx2, input logic [19:0] tag2, input logic [3:0] way2,
    input int abort_n);
    bit pv_d, pv_m;
    logic [11:0] pa;
    logic [3:0] pw;
    logic [31:0] pmd, pma;
    int limit;
    ob.delete(); ob_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    done_cyc = -1; hold_viol = 0; const_viol = 0; extra_acc = 0;
    acc0 = 1'b1; next_acc = 1'b0;
    pv_d = 0; pv_m = 0; pa = '0; pw = '0; pmd = '0; pma = '0;
    limit = mstall + 400;
    if (!skip_acc) begin
      @(negedge clock);
      io_req_valid = 1'b1;
      io_req_bits_idx = idx;
      io_req_bits_tag = tag;
      io_req_bits_way_en = way;
      acc0 = io_req_ready;
    end
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      io_req_valid = hold;
      if (hold) begin
        io_req_bits_idx = idx2;
        io_req_bits_tag = tag2;
        io_req_bits_way_en = way2;
      end
      io_data_req_ready = (dmode == 0) ? 1'b1 :
                          (dmode == 1) ? c[0] : ($urandom_range(0, 1) == 1);
      io_mem_ready = (c <= mstall) ? 1'b0 :
                     (mmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (pv_d && !(io_data_req_valid && io_data_req_bits_addr == pa &&
                    io_data_req_bits_way_en == pw)) hold_viol++;
      if (pv_m && !(io_mem_valid && io_mem_bits_data == pmd &&
                    io_mem_bits_addr == pma)) hold_viol++;
      if (io_data_req_valid && (io_data_req_bits_write ||
          io_data_req_bits_wdata != 0 || io_data_req_bits_eccMask != 0 ||
          io_data_req_bits_way_en != way)) const_viol++;
      if (io_data_req_valid && io_data_req_ready) begin
        rd_addr.push_back(io_data_req_bits_addr);
        rd_cyc.push_back(c);
      end
      pv_d = io_data_req_valid && !io_data_req_ready;
      pa = io_data_req_bits_addr;
      pw = io_data_req_bits_way_en;
      if (io_mem_valid && io_mem_ready) begin
        ob.push_back({io_mem_bits_data, io_mem_bits_addr, io_mem_bits_last});
        ob_cyc.push_back(c);
      end
      pv_m = io_mem_valid && !io_mem_ready;
      pmd = io_mem_bits_data;
      pma = io_mem_bits_addr;
      if (io_done) begin
        done_cyc = c;
        next_acc = hold & io_req_ready;
        break;
      end else if (io_req_valid && io_req_ready) extra_acc++;
      if (abort_n > 0 && ob.size() >= abort_n) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    io_req_valid = 1'b0;
    io_data_req_ready = 1'b0;
    io_mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outs got %h exp 0", outs);
    end
    total++;
    if (io_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready got %b exp 1", io_req_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [96:0] g, e;
    logic [43:0] gr, er;
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < 16; w++)
        arr[i][w] = (i == 1) ? 32'(w) : 32'hDEADBEEF;
    run_line(6'h05, 20'hABCDE, 4'b0010, 0, 0, 0, 0, 0, '0, '0, '0, 0);
    total++;
    if (acc0 !== 1'b1) begin bad++; $display("FAIL t1_ready got %b exp 1", acc0); end
    for (int w = 0; w < 16; w++) begin
      gr = (w < rd_addr.size()) ? {rd_addr[w], rd_cyc[w]} : 'x;
      er = {12'(12'h140 + 4 * w), 32'(1 + w)};
      total++;
      if (gr !== er) begin bad++; $display("FAIL t1_read%0d got %h exp %h", w, gr, er); end
    end
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? {ob[b], ob_cyc[b]} : 'x;
      e = {32'(b), 20'hABCDE, 6'h05, 4'(b), 2'b00, (b == 15), 32'(3 + b)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t1_beat%0d got %h exp %h", b, g, e); end
    end
    total++;
    if (done_cyc !== 19) begin bad++; $display("FAIL t1_done_cyc got %0d exp 19", done_cyc); end
    total++;
    if (const_viol !== 0) begin bad++; $display("FAIL t1_consts got %0d exp 0", const_viol); end
    @(negedge clock);
    total++;
    if (io_done !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got %b exp 0", io_done); end
  endtask

  task automatic test_mem_stall();
    logic [64:0] g, e;
    logic [5:0] idx;
    logic [19:0] tag;
    int nrd;
    logic [15:0] eperf;
    fill_arr();
    idx = 6'($urandom); tag = 20'($urandom);
    run_line(idx, tag, 4'b0100, 22, 0, 0, 0, 0, '0, '0, '0, 0);
    nrd = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] <= 22) nrd++;
    total++;
    if (nrd !== 3) begin bad++; $display("FAIL t2_reads_in_stall got %0d exp 3", nrd); end
    total++;
    if (hold_viol !== 0) begin bad++; $display("FAIL t2_hold got %0d exp 0", hold_viol); end
    total++;
    if (ob.size() !== 16) begin bad++; $display("FAIL t2_count got %0d exp 16", ob.size()); end
    total++;
    if (ob_cyc.size() == 0 || ob_cyc[0] !== 23) begin
      bad++; $display("FAIL t2_first_beat_cyc got %0d exp 23",
                      ob_cyc.size() == 0 ? -1 : ob_cyc[0]);
    end
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? ob[b] : 'x;
      e = {exp_word(4'b0100, b), tag, idx, 4'(b), 2'b00, (b == 15)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t2_beat%0d got %h exp %h", b, g, e); end
    end
`ifdef DCACHE_WB_PERF_EN
    eperf = 16'd20;
`else
    eperf = 16'd0;
`endif
    total++;
    if (io_perf_stall_cycles !== eperf) begin
      bad++; $display("FAIL t2_perf got %0d exp %0d", io_perf_stall_cycles, eperf);
    end
  endtask

  task automatic test_dreq_alt();
    logic [64:0] g, e;
    fill_arr();
    run_line(6'h2A, 20'h13579, 4'b1000, 0, 1, 0, 0, 0, '0, '0, '0, 0);
    total++;
    if (hold_viol !== 0) begin bad++; $display("FAIL t3_hold got %0d exp 0", hold_viol); end
    total++;
    if (rd_addr.size() !== 16) begin
      bad++; $display("FAIL t3_reads got %0d exp 16", rd_addr.size());
    end
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? ob[b] : 'x;
      e = {exp_word(4'b1000, b), 20'h13579, 6'h2A, 4'(b), 2'b00, (b == 15)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t3_beat%0d got %h exp %h", b, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] g, e;
    fill_arr();
    run_line(6'h11, 20'hF00D1, 4'b0001, 0, 0, 0, 0, 1,
             6'h22, 20'h0BEEF, 4'b0110, 0);
    total++;
    if (extra_acc !== 0) begin bad++; $display("FAIL t4_extra_acc got %0d exp 0", extra_acc); end
    total++;
    if (next_acc !== 1'b1) begin bad++; $display("FAIL t4_done_acc got %b exp 1", next_acc); end
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? ob[b] : 'x;
      e = {exp_word(4'b0001, b), 20'hF00D1, 6'h11, 4'(b), 2'b00, (b == 15)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t4a_beat%0d got %h exp %h", b, g, e); end
    end
    run_line(6'h22, 20'h0BEEF, 4'b0110, 0, 0, 0, 1, 0, '0, '0, '0, 0);
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? ob[b] : 'x;
      e = {exp_word(4'b0110, b), 20'h0BEEF, 6'h22, 4'(b), 2'b00, (b == 15)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t4b_beat%0d got %h exp %h", b, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [64:0] g, e;
    fill_arr();
    run_line(6'h3F, 20'hFFFFF, 4'b1001, 0, 0, 0, 0, 0, '0, '0, '0, 6);
    total++;
    if (ob.size() !== 6) begin bad++; $display("FAIL t5_pre_count got %0d exp 6", ob.size()); end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (outs !== '0) begin bad++; $display("FAIL t5_reset_outs got %h exp 0", outs); end
    total++;
    if (io_req_ready !== 1'b1) begin
      bad++; $display("FAIL t5_req_ready got %b exp 1", io_req_ready);
    end
    @(negedge clock);
    io_req_valid = 1'b0;
    reset_n = 1'b1;
    run_line(6'h07, 20'h24680, 4'b0100, 0, 0, 0, 0, 0, '0, '0, '0, 0);
    for (int b = 0; b < 16; b++) begin
      g = (b < ob.size()) ? ob[b] : 'x;
      e = {exp_word(4'b0100, b), 20'h24680, 6'h07, 4'(b), 2'b00, (b == 15)};
      total++;
      if (g !== e) begin bad++; $display("FAIL t5_beat%0d got %h exp %h", b, g, e); end
    end
  endtask

  task automatic test_random();
    logic [64:0] g, e;
    logic [5:0] idx;
    logic [19:0] tag;
    logic [3:0] way;
    for (int n = 0; n < 6; n++) begin
      fill_arr();
      idx = 6'($urandom); tag = 20'($urandom);
      way = (n == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      run_line(idx, tag, way, 0, 2, 2, 0, 0, '0, '0, '0, 0);
      total++;
      if (hold_viol !== 0 || const_viol !== 0) begin
        bad++; $display("FAIL rnd%0d_stable got %0d/%0d exp 0/0", n, hold_viol, const_viol);
      end
      total++;
      if (ob.size() !== 16 || done_cyc !== ob_cyc[15] + 1) begin
        bad++; $display("FAIL rnd%0d_done got n=%0d done=%0d exp n=16 done=last+1",
                        n, ob.size(), done_cyc);
      end
      for (int b = 0; b < 16; b++) begin
        g = (b < ob.size()) ? ob[b] : 'x;
        e = {exp_word(way, b), tag, idx, 4'(b), 2'b00, (b == 15)};
        total++;
        if (g !== e) begin bad++; $display("FAIL rnd%0d_beat%0d got %h exp %h", n, b, g, e); end
      end
    end
  endtask

`ifdef DCACHE_WB_PERF_EN
  task automatic test_perf_sat();
    fill_arr();
    run_line(6'h01, 20'h00001, 4'b0001, 70000, 0, 0, 0, 0, '0, '0, '0, 0);
    total++;
    if (io_perf_stall_cycles !== 16'hFFFF) begin
      bad++; $display("FAIL perf_sat got %h exp ffff", io_perf_stall_cycles);
    end
    total++;
    if (ob.size() !== 16) begin bad++; $display("FAIL perf_sat_count got %0d exp 16", ob.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_mem_stall();
    test_dreq_alt();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DCACHE_WB_PERF_EN
    test_perf_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
